// File: rtl/tx_store_forward_fifo.sv
// Transmit store-and-forward FIFO: packets are buffered whole and released towards the MAC
// only after a clean tlast, so egress never underruns in the middle of a packet.
module tx_store_forward_fifo #(
    parameter int DATA_WIDTH  = 64,
    parameter int DEPTH       = 512,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                      clk156,
    input  logic                      reset,
    input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0]   s_axis_tkeep,
    input  logic                      s_axis_tvalid,
    input  logic                      s_axis_tlast,
    input  logic                      s_axis_tuser,
    output logic                      s_axis_tready,
    output logic [DATA_WIDTH-1:0]     m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]   m_axis_tkeep,
    output logic                      m_axis_tvalid,
    output logic                      m_axis_tlast,
    input  logic                      m_axis_tready,
    output logic [COUNT_WIDTH-1:0]    pkt_count,
    output logic [COUNT_WIDTH-1:0]    drop_count,
    output logic [$clog2(DEPTH):0]    fifo_level
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int KW = DATA_WIDTH / 8;
    localparam int MW = DATA_WIDTH + KW + 1;
    localparam logic [PW-1:0]          PTR_ONE   = PW'(1);
    localparam logic [PW-1:0]          PTR_DEPTH = PW'(DEPTH);
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE   = COUNT_WIDTH'(1);

    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          commit_ptr_q, commit_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic                   drop_mode_q, drop_mode_d;
    logic                   s_ready_q, s_ready_d;
    logic                   ram_valid_q, ram_valid_d;
    logic                   m_valid_q, m_valid_d;
    logic [COUNT_WIDTH-1:0] pkt_count_q, pkt_count_d;
    logic [COUNT_WIDTH-1:0] drop_count_q, drop_count_d;

    logic                   accept_s;
    logic                   wr_en_s;
    logic                   rd_en_s;
    logic                   out_ready_s;
    logic                   full_next_s;
    logic [PW-1:0]          level_next_s;

    logic [MW-1:0]          mem [DEPTH];
    logic [MW-1:0]          ram_dout_q;
    logic [MW-1:0]          m_word_q;

    // Ingress accounting, egress prefetch and next-state ready/drop decision.
    always_comb begin
        accept_s     = s_axis_tvalid && s_ready_q;
        wr_en_s      = 1'b0;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        drop_mode_d  = drop_mode_q;
        pkt_count_d  = pkt_count_q;
        drop_count_d = drop_count_q;
        if (accept_s) begin
            if (drop_mode_q || (s_axis_tlast && s_axis_tuser)) begin
                // Discarded beats are swallowed; the final one rewinds to the last commit.
                if (s_axis_tlast) begin
                    wr_ptr_d     = commit_ptr_q;
                    drop_count_d = drop_count_q + CNT_ONE;
                    drop_mode_d  = 1'b0;
                end else begin
                    wr_ptr_d     = wr_ptr_q;
                end
            end else if (s_axis_tlast) begin
                wr_en_s      = 1'b1;
                wr_ptr_d     = wr_ptr_q + PTR_ONE;
                commit_ptr_d = wr_ptr_q + PTR_ONE;
                pkt_count_d  = pkt_count_q + CNT_ONE;
            end else begin
                wr_en_s      = 1'b1;
                wr_ptr_d     = wr_ptr_q + PTR_ONE;
            end
        end else begin
            wr_en_s = 1'b0;
        end

        // Two-stage egress (RAM output, then output register) keeps one beat per cycle.
        out_ready_s = !m_valid_q || m_axis_tready;
        rd_en_s     = (rd_ptr_q != commit_ptr_q) && (!ram_valid_q || out_ready_s);
        if (rd_en_s) begin
            rd_ptr_d    = rd_ptr_q + PTR_ONE;
            ram_valid_d = 1'b1;
        end else if (out_ready_s) begin
            rd_ptr_d    = rd_ptr_q;
            ram_valid_d = 1'b0;
        end else begin
            rd_ptr_d    = rd_ptr_q;
            ram_valid_d = ram_valid_q;
        end
        if (out_ready_s) begin
            m_valid_d = ram_valid_q;
        end else begin
            m_valid_d = m_valid_q;
        end

        // A packet that fills the buffer on its own can never commit: switch to dropping it.
        level_next_s = wr_ptr_d - rd_ptr_d;
        full_next_s  = (level_next_s == PTR_DEPTH);
        drop_mode_d  = drop_mode_d || (full_next_s && (commit_ptr_d == rd_ptr_d));
        s_ready_d    = !full_next_s || drop_mode_d;
    end

    // Control state, cleared asynchronously.
    always_ff @(posedge clk156 or posedge reset) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            drop_mode_q  <= 1'b0;
            s_ready_q    <= 1'b0;
            ram_valid_q  <= 1'b0;
            m_valid_q    <= 1'b0;
            pkt_count_q  <= '0;
            drop_count_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            drop_mode_q  <= drop_mode_d;
            s_ready_q    <= s_ready_d;
            ram_valid_q  <= ram_valid_d;
            m_valid_q    <= m_valid_d;
            pkt_count_q  <= pkt_count_d;
            drop_count_q <= drop_count_d;
        end
    end

    // Simple dual-port packet RAM write port.
    always_ff @(posedge clk156) begin
        if (wr_en_s) begin
            mem[wr_ptr_q[AW-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
        end
    end

    // Registered RAM read port and output data register.
    always_ff @(posedge clk156) begin
        if (rd_en_s) begin
            ram_dout_q <= mem[rd_ptr_q[AW-1:0]];
        end
        if (out_ready_s && ram_valid_q) begin
            m_word_q <= ram_dout_q;
        end
    end

    assign s_axis_tready = s_ready_q;
    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tdata  = m_word_q[DATA_WIDTH-1:0];
    assign m_axis_tkeep  = m_word_q[DATA_WIDTH+KW-1:DATA_WIDTH];
    assign m_axis_tlast  = m_word_q[MW-1];
    assign pkt_count     = pkt_count_q;
    assign drop_count    = drop_count_q;
    assign fifo_level    = wr_ptr_q - rd_ptr_q;

endmodule

// File: tb/tb_tx_store_forward_fifo.sv
// Bench for tx_store_forward_fifo (64-bit data, 16-beat buffer): a packet table plus latency,
// back-pressure, oversize, back-to-back and reset sequences, checked by an egress scoreboard.
`timescale 1ns/1ps
module tb_tx_store_forward_fifo;
    localparam int DW    = 64;
    localparam int DEPTH = 16;
    localparam int CW    = 32;
    localparam int KW    = DW / 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] s_data;
    logic [KW-1:0] s_keep;
    logic          s_valid, s_last, s_user, s_ready;
    logic [DW-1:0] m_data;
    logic [KW-1:0] m_keep;
    logic          m_valid, m_last, m_ready;
    logic [CW-1:0] pkt_count, drop_count;
    logic [4:0]    fifo_level;

    tx_store_forward_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .COUNT_WIDTH(CW)) dut (
        .clk156(clk), .reset(reset),
        .s_axis_tdata(s_data), .s_axis_tkeep(s_keep), .s_axis_tvalid(s_valid),
        .s_axis_tlast(s_last), .s_axis_tuser(s_user), .s_axis_tready(s_ready),
        .m_axis_tdata(m_data), .m_axis_tkeep(m_keep), .m_axis_tvalid(m_valid),
        .m_axis_tlast(m_last), .m_axis_tready(m_ready),
        .pkt_count(pkt_count), .drop_count(drop_count), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    typedef logic [DW+KW:0] beat_t;
    typedef struct {
        int len;
        bit bad;
        int pkt_inc;
        int drop_inc;
    } vec_t;

    beat_t sb[$];
    int    total = 0;
    int    bad = 0;
    int    exp_pkt = 0;
    int    exp_drop = 0;
    int    run_len = 0;
    int    max_run = 0;
    bit    stall_prev = 1'b0;
    beat_t prev_beat;
    bit    tog_on;
    int    st;
    vec_t  vecs[8];

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Egress monitor: scoreboard compare on handshakes, hold check while stalled.
    always @(negedge clk) begin
        beat_t cur;
        beat_t exp;
        cur = {m_last, m_keep, m_data};
        if (reset) begin
            stall_prev = 1'b0;
            run_len    = 0;
        end else begin
            if (m_valid) begin
                run_len++;
                if (run_len > max_run) max_run = run_len;
            end else begin
                run_len = 0;
            end
            if (stall_prev) begin
                total++;
                if (!m_valid || cur !== prev_beat) begin
                    bad++;
                    $display("FAIL stall hold: got valid=%0d beat=%h expected valid=1 beat=%h",
                             m_valid, cur, prev_beat);
                end
            end
            if (m_valid && m_ready) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL egress beat: got %h expected none", cur);
                end else begin
                    exp = sb.pop_front();
                    if (cur !== exp) begin
                        bad++;
                        $display("FAIL egress beat: got %h expected %h", cur, exp);
                    end
                end
            end
            stall_prev = m_valid && !m_ready;
            prev_beat  = cur;
        end
    end

    task automatic send_pkt(input int len, input bit is_bad, input bit expect_out,
                            input int pid, output int stalls);
        beat_t beats[$];
        logic [7:0] k;
        stalls = 0;
        for (int i = 0; i < len; i++) begin
            int w;
            k       = 8'hFF;
            k       = k >> (pid % 8);
            s_data  = {32'(pid), 32'(i)};
            s_last  = (i == len - 1);
            s_keep  = s_last ? k : 8'hFF;
            s_user  = is_bad && s_last;
            s_valid = 1'b1;
            w = 0;
            while (!s_ready && w < 200) begin
                @(posedge clk); #1;
                w++;
                stalls++;
            end
            if (!s_ready) begin
                total++;
                bad++;
                $display("FAIL ingress timeout: got s_ready=0 expected 1 (pkt %0d beat %0d)", pid, i);
                s_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
            beats.push_back({s_last, s_keep, s_data});
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_user  = 1'b0;
        if (expect_out) begin
            foreach (beats[j]) sb.push_back(beats[j]);
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((sb.size() != 0 || m_valid) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (4) @(posedge clk);
        #1;
        check({name, " drained"}, sb.size(), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{len: 4,  bad: 1'b1, pkt_inc: 0, drop_inc: 1};
        vecs[1] = '{len: 3,  bad: 1'b0, pkt_inc: 1, drop_inc: 0};
        vecs[2] = '{len: 1,  bad: 1'b0, pkt_inc: 1, drop_inc: 0};
        vecs[3] = '{len: 16, bad: 1'b0, pkt_inc: 1, drop_inc: 0};
        vecs[4] = '{len: 1,  bad: 1'b1, pkt_inc: 0, drop_inc: 1};
        vecs[5] = '{len: 20, bad: 1'b0, pkt_inc: 0, drop_inc: 1};
        vecs[6] = '{len: 17, bad: 1'b1, pkt_inc: 0, drop_inc: 1};
        vecs[7] = '{len: 2,  bad: 1'b0, pkt_inc: 1, drop_inc: 0};

        s_data = '0; s_keep = '0; s_valid = 1'b0; s_last = 1'b0; s_user = 1'b0;
        m_ready = 1'b1;
        #1 reset = 1'b1;
        #1;
        check("reset s_ready", s_ready, 0);
        check("reset m_valid", m_valid, 0);
        check("reset pkt_count", pkt_count, 0);
        check("reset drop_count", drop_count, 0);
        check("reset level", fifo_level, 0);
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        check("s_ready after reset", s_ready, 1);

        // First beat appears two edges after the tlast handshake.
        send_pkt(5, 1'b0, 1'b1, 1, st);
        exp_pkt++;
        check("latency edge0", m_valid, 0);
        @(posedge clk); #1;
        check("latency edge1", m_valid, 0);
        @(posedge clk); #1;
        check("latency edge2", m_valid, 1);
        drain("pkt5");
        check("pkt5 pkt_count", pkt_count, exp_pkt);
        check("pkt5 level", fifo_level, 0);

        for (int v = 0; v < 8; v++) begin
            send_pkt(vecs[v].len, vecs[v].bad, vecs[v].pkt_inc != 0, 100 + v, st);
            exp_pkt  += vecs[v].pkt_inc;
            exp_drop += vecs[v].drop_inc;
            drain($sformatf("vec%0d", v));
            check($sformatf("vec%0d pkt_count", v), pkt_count, exp_pkt);
            check($sformatf("vec%0d drop_count", v), drop_count, exp_drop);
            check($sformatf("vec%0d level", v), fifo_level, 0);
            check($sformatf("vec%0d ingress stalls", v), st, 0);
        end

        // Full with committed data: ingress stalls, nothing is dropped.
        m_ready = 1'b0;
        send_pkt(8, 1'b0, 1'b1, 10, st);
        send_pkt(8, 1'b0, 1'b1, 11, st);
        fork
            begin
                int st3;
                send_pkt(8, 1'b0, 1'b1, 12, st3);
            end
            begin
                int n;
                n = 0;
                while (s_ready && n < 100) begin
                    @(posedge clk); #1;
                    n++;
                end
                check("full s_ready", s_ready, 0);
                check("full level", fifo_level, 16);
                check("full drop_count", drop_count, exp_drop);
                repeat (5) @(posedge clk);
                #1;
                check("full level held", fifo_level, 16);
                m_ready = 1'b1;
            end
        join
        exp_pkt += 3;
        drain("full3");
        check("full3 pkt_count", pkt_count, exp_pkt);
        check("full3 drop_count", drop_count, exp_drop);

        // Back-to-back short packets stream without a bubble.
        max_run = 0;
        send_pkt(2, 1'b0, 1'b1, 20, st);
        send_pkt(2, 1'b0, 1'b1, 21, st);
        exp_pkt += 2;
        drain("b2b");
        check("b2b valid run", max_run, 4);

        // Random egress back-pressure.
        tog_on = 1'b1;
        fork
            begin
                int sr;
                send_pkt(3, 1'b0, 1'b1, 30, sr);
                send_pkt(5, 1'b0, 1'b1, 31, sr);
                send_pkt(2, 1'b0, 1'b1, 32, sr);
                send_pkt(7, 1'b0, 1'b1, 33, sr);
                send_pkt(4, 1'b0, 1'b1, 34, sr);
                tog_on = 1'b0;
            end
            begin
                while (tog_on) begin
                    @(posedge clk); #1;
                    m_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        m_ready = 1'b1;
        exp_pkt += 5;
        drain("random");
        check("random pkt_count", pkt_count, exp_pkt);
        check("random level", fifo_level, 0);

        // Reset in the middle of a packet discards everything, no drop counted.
        for (int i = 0; i < 2; i++) begin
            s_data = {32'd50, 32'(i)}; s_keep = 8'hFF; s_last = 1'b0; s_user = 1'b0; s_valid = 1'b1;
            @(posedge clk); #1;
        end
        s_data = {32'd50, 32'd2};
        #2 reset = 1'b1;
        #1;
        check("midreset s_ready", s_ready, 0);
        check("midreset m_valid", m_valid, 0);
        check("midreset pkt_count", pkt_count, 0);
        check("midreset drop_count", drop_count, 0);
        check("midreset level", fifo_level, 0);
        s_valid = 1'b0;
        sb.delete();
        exp_pkt  = 0;
        exp_drop = 0;
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        check("post-reset s_ready", s_ready, 1);
        send_pkt(2, 1'b0, 1'b1, 60, st);
        exp_pkt++;
        drain("post-reset");
        check("post-reset pkt_count", pkt_count, exp_pkt);
        check("post-reset drop_count", drop_count, exp_drop);
        check("post-reset level", fifo_level, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tx_store_forward_fifo.md
TX_STORE_FORWARD_FIFO -- requirements
Module: tx_store_forward_fifo

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 64, meaning tdata width in bits (64, 128, 256 or 512).
REQ-002 The block SHALL have parameter DEPTH, default 512, meaning buffer depth in beats (power of two, >= 4).
REQ-003 The block SHALL have parameter COUNT_WIDTH, default 32, meaning statistics counter width.
REQ-004 The block SHALL have port clk156, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have ports s_axis_tdata/tkeep/tvalid/tlast/tuser, input, DATA_WIDTH/DATA_WIDTH/8/1/1/1: ingress stream; tuser=1 on the tlast beat marks the packet bad.
REQ-007 The block SHALL have port s_axis_tready, output, 1 bit: ingress ready.
REQ-008 The block SHALL have ports m_axis_tdata/tkeep/tvalid/tlast, output, DATA_WIDTH/DATA_WIDTH/8/1/1: egress stream towards the MAC.
REQ-009 The block SHALL have port m_axis_tready, input, 1 bit: egress ready.
REQ-010 The block SHALL have ports pkt_count and drop_count, output, COUNT_WIDTH each: committed and dropped packet totals.
REQ-011 The block SHALL have port fifo_level, output, clog2(DEPTH)+1 bits: stored beats, committed plus in-progress.

Function
REQ-012 Pointers wr_ptr, commit_ptr and rd_ptr SHALL each be clog2(DEPTH)+1 bits and wrap modulo 2*DEPTH; full = (wr_ptr - rd_ptr == DEPTH).
REQ-013 An ingress beat SHALL be accepted when s_axis_tvalid && s_axis_tready; accepted beats are written at wr_ptr, and wr_ptr then increments.
REQ-014 s_axis_tready SHALL be !full || drop_mode.
REQ-015 A tlast beat accepted with tuser=0 while not in drop_mode SHALL set commit_ptr to wr_ptr+1 and increment pkt_count on the same edge.
REQ-016 A tlast beat accepted with tuser=1 SHALL set wr_ptr to commit_ptr (rewind), leave commit_ptr unchanged, and increment drop_count.
REQ-017 Oversize handling: when full and commit_ptr == rd_ptr (the in-progress packet alone fills the buffer), drop_mode SHALL be set.
REQ-018 In drop_mode, beats SHALL be accepted but not written; the tlast beat SHALL rewind wr_ptr to commit_ptr, increment drop_count once, and clear drop_mode.
REQ-019 When full with committed data present (commit_ptr != rd_ptr), ingress SHALL stall with s_axis_tready=0 and no drop.
REQ-020 Egress SHALL present only committed beats (rd_ptr != commit_ptr), so a packet once started is never interrupted by underrun.
REQ-021 Egress SHALL use a first-word-fall-through output register; data and tvalid are held stable while m_axis_tvalid && !m_axis_tready.
REQ-022 Latency: the first beat of a packet SHALL appear on m_axis_tvalid 2 clk156 edges after its tlast ingress handshake when the egress is idle.
REQ-023 With continuous m_axis_tready, egress throughput SHALL be 1 beat/cycle across packet boundaries with no bubble.
REQ-024 A simultaneous ingress write and egress read at full SHALL be legal, and the level SHALL be unchanged.
REQ-025 Counters SHALL wrap from 2^COUNT_WIDTH-1 to 0; fifo_level = wr_ptr - rd_ptr.
REQ-026 Storage SHALL be a simple dual-port RAM of DEPTH x (DATA_WIDTH + DATA_WIDTH/8 + 1) with 1-cycle read latency.

Reset
REQ-027 On reset assertion, all pointers, drop_mode, pkt_count, drop_count, m_axis_tvalid and s_axis_tready SHALL go to 0 immediately; m_axis_tdata/tkeep/tlast are don't-care.
REQ-028 s_axis_tready SHALL rise on the first edge after reset deasserts.
REQ-029 A reset asserted mid-packet SHALL discard all stored and in-progress data, with no drop_count increment.

Verification
REQ-030 DATA_WIDTH=64, DEPTH=16: send a 5-beat packet with tuser=0 and m_axis_tready=1 -> m_axis_tvalid rises 2 cycles after the tlast handshake, 5 beats are output with tlast on beat 5, pkt_count=1, fifo_level returns to 0.
REQ-031 Send a 4-beat packet with tuser=1 on tlast -> no egress beats, drop_count=1, fifo_level=0; a following 3-beat good packet is output intact.
REQ-032 DEPTH=16, send a 20-beat packet -> drop_mode at beat 17, all 20 beats accepted, drop_count=1, no egress, s_axis_tready stays 1.
REQ-033 Hold m_axis_tready=0 with two committed 8-beat packets, then offer a third packet -> s_axis_tready=0 at level 16 and no drop; after m_axis_tready=1 all 3 packets are output in order, pkt_count=3.
REQ-034 Two back-to-back 2-beat packets with m_axis_tready=1 -> 4 consecutive valid egress cycles; random m_axis_tready toggling -> data stable while stalled and no beat lost or duplicated.
REQ-035 Assert reset on beat 3 of a 6-beat packet -> all outputs and counters are 0 within the same cycle; a post-reset 2-beat packet passes correctly.
